// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-port arbiter and its response tracker.
package mem_pkg;

    // Native data/address width of the memory manager's data port.
    localparam int MEM_WIDTH = 32;

    // Access size codes as carried on the request and memory buses.
    typedef enum logic [2:0] {
        SZ_B = 3'd0,
        SZ_H = 3'd1,
        SZ_W = 3'd2,
        SZ_D = 3'd3,
        SZ_Q = 3'd4
    } size_e;

    // One requester's payload, bundled so both requesters are handled alike.
    typedef struct packed {
        logic                 write;
        logic [MEM_WIDTH-1:0] addr;
        logic [2:0]           bytes;
        logic                 is_unsigned;
        logic [MEM_WIDTH-1:0] wdata;
    } mem_req_t;

    // True when the access cannot be serviced: the size exceeds the port width
    // or the address is not aligned to the access size.
    function automatic logic is_misaligned(input logic [MEM_WIDTH-1:0] addr,
                                           input logic [2:0]           bytes,
                                           input int                   width);
        logic [MEM_WIDTH-1:0] mask;
        if ((32'd1 << bytes) > 32'(width / 8)) begin
            return 1'b1;
        end
        mask = (MEM_WIDTH'(1) << bytes) - MEM_WIDTH'(1);
        return (addr & mask) != '0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rsp_tracker.sv
// One-deep response slot for a single requester. A grant in cycle N produces
// the response pulse in cycle N+1; load data is steered from the memory read
// bus, stores and errors return zero data.
module arb_rsp_tracker #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             grant,
    input  logic             is_read,
    input  logic             err,
    input  logic [WIDTH-1:0] m_rd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    logic slot_read;
    logic slot_err;

    // Capture the kind of access granted this cycle; reset drops any pending slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            slot_read <= 1'b0;
            slot_err  <= 1'b0;
        end else begin
            rsp_valid <= grant;
            slot_read <= grant & is_read;
            slot_err  <= grant & err;
        end
    end

    assign rsp_err   = rsp_valid & slot_err;
    assign rsp_rdata = (rsp_valid & slot_read) ? m_rd_data : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory manager's data load/store port between the core LSU
// (requester 0) and the debug/DMA master (requester 1). One read and one write
// may issue together; a write is held off for the cycle after a dual issue
// whose read and write hit different words, because the memory manager defers
// that write and cannot accept another behind it.
//
// Handshake: a request transfers on any cycle where valid && ready. ready is a
// combinational grant that may depend on valid and payload; the requester must
// hold its payload stable while valid && !ready. Responses have no
// backpressure and arrive exactly one cycle after the transfer.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_req_valid,
    output logic             r0_req_ready,
    input  logic             r0_req_write,
    input  logic [WIDTH-1:0] r0_req_addr,
    input  logic [2:0]       r0_req_bytes,
    input  logic             r0_req_unsigned,
    input  logic [WIDTH-1:0] r0_req_wdata,
    output logic             r0_rsp_valid,
    output logic [WIDTH-1:0] r0_rsp_rdata,
    output logic             r0_rsp_err,

    input  logic             r1_req_valid,
    output logic             r1_req_ready,
    input  logic             r1_req_write,
    input  logic [WIDTH-1:0] r1_req_addr,
    input  logic [2:0]       r1_req_bytes,
    input  logic             r1_req_unsigned,
    input  logic [WIDTH-1:0] r1_req_wdata,
    output logic             r1_rsp_valid,
    output logic [WIDTH-1:0] r1_rsp_rdata,
    output logic             r1_rsp_err,

    output logic [WIDTH-1:0] m_wr_addr,
    output logic             m_we,
    output logic [2:0]       m_wr_bytes,
    output logic [WIDTH-1:0] m_wr_data,
    output logic [WIDTH-1:0] m_rd_addr,
    output logic             m_re,
    output logic [2:0]       m_rd_bytes,
    output logic             m_rd_unsigned,
    input  logic [WIDTH-1:0] m_rd_data
);

    // WIDTH must equal MEM_WIDTH so the payload fits the shared request struct.
    localparam int BYTES = WIDTH / 8;
    localparam int ALIGN = $clog2(BYTES);
    localparam int CW    = $clog2(MAX_WAIT + 1);

    mem_req_t        req0;
    mem_req_t        req1;
    logic            err0, err1;
    logic            rd0, rd1;
    logic            wr0, wr1;
    logic            wr_free;
    logic            r1_prio;
    logic            rd_sel1;
    logic            wr_sel1;
    logic            wr_block;
    logic            wr_block_next;
    logic [CW-1:0]   starve_cnt;

    assign req0 = {r0_req_write, r0_req_addr, r0_req_bytes, r0_req_unsigned, r0_req_wdata};
    assign req1 = {r1_req_write, r1_req_addr, r1_req_bytes, r1_req_unsigned, r1_req_wdata};

    // Classify each request: error (no port), legal read, or legal write.
    always_comb begin
        err0 = r0_req_valid & is_misaligned(req0.addr, req0.bytes, WIDTH);
        err1 = r1_req_valid & is_misaligned(req1.addr, req1.bytes, WIDTH);
        rd0  = r0_req_valid & ~err0 & ~req0.write;
        rd1  = r1_req_valid & ~err1 & ~req1.write;
        wr0  = r0_req_valid & ~err0 &  req0.write;
        wr1  = r1_req_valid & ~err1 &  req1.write;
    end

    assign wr_free = ~wr_block;
    assign r1_prio = (starve_cnt == CW'(MAX_WAIT));

    // Grant: the priority holder takes its port if available; the other
    // requester gets whatever port the holder did not claim. Errors use no port.
    always_comb begin
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        if (rst_n) begin
            if (r1_prio) begin
                r1_req_ready = err1 | rd1 | (wr1 & wr_free);
                r0_req_ready = err0 | (rd0 & ~rd1) | (wr0 & wr_free & ~wr1);
            end else begin
                r0_req_ready = err0 | rd0 | (wr0 & wr_free);
                r1_req_ready = err1 | (rd1 & ~rd0) | (wr1 & wr_free & ~wr0);
            end
        end
    end

    // Drive the memory ports from whichever granted request owns each port.
    always_comb begin
        rd_sel1       = r1_req_ready & rd1;
        wr_sel1       = r1_req_ready & wr1;
        m_re          = (r0_req_ready & rd0) | rd_sel1;
        m_we          = (r0_req_ready & wr0) | wr_sel1;
        m_rd_addr     = rd_sel1 ? req1.addr        : req0.addr;
        m_rd_bytes    = rd_sel1 ? req1.bytes       : req0.bytes;
        m_rd_unsigned = rd_sel1 ? req1.is_unsigned : req0.is_unsigned;
        m_wr_addr     = wr_sel1 ? req1.addr        : req0.addr;
        m_wr_bytes    = wr_sel1 ? req1.bytes       : req0.bytes;
        m_wr_data     = wr_sel1 ? req1.wdata       : req0.wdata;
        wr_block_next = m_re & m_we &
                        (m_rd_addr[WIDTH-1:ALIGN] != m_wr_addr[WIDTH-1:ALIGN]);
    end

    // Track requester 1 starvation and the one-cycle write block after a deferred write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            wr_block   <= 1'b0;
        end else begin
            wr_block <= wr_block_next;
            if (!r1_req_valid || r1_req_ready) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CW'(MAX_WAIT)) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

    arb_rsp_tracker #(.WIDTH(WIDTH)) u_rsp0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (r0_req_ready),
        .is_read   (rd0),
        .err       (err0),
        .m_rd_data (m_rd_data),
        .rsp_valid (r0_rsp_valid),
        .rsp_rdata (r0_rsp_rdata),
        .rsp_err   (r0_rsp_err)
    );

    arb_rsp_tracker #(.WIDTH(WIDTH)) u_rsp1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (r1_req_ready),
        .is_read   (rd1),
        .err       (err1),
        .m_rd_data (m_rd_data),
        .rsp_valid (r1_rsp_valid),
        .rsp_rdata (r1_rsp_rdata),
        .rsp_err   (r1_rsp_err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycles with literal expectations plus a
// per-cycle reference model of the grant rules and response data.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int W        = 32;
    localparam int MAX_WAIT = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           vld [2];
    mem_req_t       req [2];

    logic           r0_req_ready, r1_req_ready;
    logic           r0_rsp_valid, r1_rsp_valid;
    logic [W-1:0]   r0_rsp_rdata, r1_rsp_rdata;
    logic           r0_rsp_err, r1_rsp_err;
    logic [W-1:0]   m_wr_addr, m_wr_data, m_rd_addr, m_rd_data;
    logic           m_we, m_re, m_rd_unsigned;
    logic [2:0]     m_wr_bytes, m_rd_bytes;

    int             n_cmp = 0;
    int             n_bad = 0;

    // bench memory (acts as memory manager) and reference memory (model)
    logic [7:0]     mem [256];
    logic [7:0]     ref_mem [256];
    bit             mem_ready = 1'b0;
    bit             ref_ready = 1'b0;

    // model state and scoreboard
    logic [W:0]     exp_q0[$];
    logic [W:0]     exp_q1[$];
    int             md_starve = 0;
    bit             md_blk = 1'b0;
    bit             exp_g [2];
    bit             prev_vld [2];
    bit             prev_g [2];
    mem_req_t       prev_req [2];

    mem_port_arbiter #(.WIDTH(W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .r0_req_valid    (vld[0]),
        .r0_req_ready    (r0_req_ready),
        .r0_req_write    (req[0].write),
        .r0_req_addr     (req[0].addr),
        .r0_req_bytes    (req[0].bytes),
        .r0_req_unsigned (req[0].is_unsigned),
        .r0_req_wdata    (req[0].wdata),
        .r0_rsp_valid    (r0_rsp_valid),
        .r0_rsp_rdata    (r0_rsp_rdata),
        .r0_rsp_err      (r0_rsp_err),
        .r1_req_valid    (vld[1]),
        .r1_req_ready    (r1_req_ready),
        .r1_req_write    (req[1].write),
        .r1_req_addr     (req[1].addr),
        .r1_req_bytes    (req[1].bytes),
        .r1_req_unsigned (req[1].is_unsigned),
        .r1_req_wdata    (req[1].wdata),
        .r1_rsp_valid    (r1_rsp_valid),
        .r1_rsp_rdata    (r1_rsp_rdata),
        .r1_rsp_err      (r1_rsp_err),
        .m_wr_addr       (m_wr_addr),
        .m_we            (m_we),
        .m_wr_bytes      (m_wr_bytes),
        .m_wr_data       (m_wr_data),
        .m_rd_addr       (m_rd_addr),
        .m_re            (m_re),
        .m_rd_bytes      (m_rd_bytes),
        .m_rd_unsigned   (m_rd_unsigned),
        .m_rd_data       (m_rd_data)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // little-endian load with sign/zero extension
    function automatic logic [W-1:0] load_val(input logic [7:0] m [256], input logic [W-1:0] a,
                                              input logic [2:0] sz, input logic uns);
        int n;
        logic [W-1:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (W'(m[8'(a + W'(i))]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic bit bad_req(input mem_req_t r);
        if (r.bytes > 3'd2) return 1'b1;
        return (r.addr % (32'd1 << r.bytes)) != 0;
    endfunction

    // memory manager stand-in: read data valid the cycle after m_re
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 48);
            mem_ready <= 1'b1;
        end else begin
            if (m_re) m_rd_data <= load_val(mem, m_rd_addr, m_rd_bytes, m_rd_unsigned);
            else      m_rd_data <= 32'hBAD0_BAD0;
            if (m_we)
                for (int i = 0; i < (1 << m_wr_bytes); i++)
                    mem[8'(m_wr_addr + W'(i))] <= m_wr_data[8*i +: 8];
        end
    end

    // reference model and per-cycle compare
    always @(negedge clk) begin
        int hi, k, rd_who, wr_who;
        bit rd_used, wr_used;
        logic [W:0] e;
        if (!ref_ready) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 48);
            ref_ready = 1'b1;
        end
        if (!rst_n) begin
            check("rst_r0_ready", r0_req_ready, 0);
            check("rst_r1_ready", r1_req_ready, 0);
            check("rst_r0_rsp_valid", r0_rsp_valid, 0);
            check("rst_r1_rsp_valid", r1_rsp_valid, 0);
            check("rst_m_re", m_re, 0);
            check("rst_m_we", m_we, 0);
            md_starve = 0;
            md_blk = 1'b0;
            exp_q0.delete();
            exp_q1.delete();
            prev_vld = '{1'b0, 1'b0};
        end else begin
            check("m_r0_rsp_valid", r0_rsp_valid, exp_q0.size() != 0);
            if (exp_q0.size() != 0) begin
                e = exp_q0.pop_front();
                check("m_r0_rsp_err", r0_rsp_err, e[W]);
                check("m_r0_rsp_rdata", r0_rsp_rdata, e[W-1:0]);
            end
            check("m_r1_rsp_valid", r1_rsp_valid, exp_q1.size() != 0);
            if (exp_q1.size() != 0) begin
                e = exp_q1.pop_front();
                check("m_r1_rsp_err", r1_rsp_err, e[W]);
                check("m_r1_rsp_rdata", r1_rsp_rdata, e[W-1:0]);
            end
            for (int j = 0; j < 2; j++)
                if (prev_vld[j] && !prev_g[j] && vld[j])
                    check("payload_stable", req[j] == prev_req[j], 1);

            // priority holder claims first; ports are single-use per cycle
            hi = (md_starve == MAX_WAIT) ? 1 : 0;
            exp_g = '{1'b0, 1'b0};
            rd_used = 1'b0; wr_used = 1'b0; rd_who = 0; wr_who = 0;
            for (int j = 0; j < 2; j++) begin
                k = (j == 0) ? hi : 1 - hi;
                if (vld[k]) begin
                    if (bad_req(req[k])) exp_g[k] = 1'b1;
                    else if (req[k].write) begin
                        if (!md_blk && !wr_used) begin exp_g[k] = 1'b1; wr_used = 1'b1; wr_who = k; end
                    end else if (!rd_used) begin
                        exp_g[k] = 1'b1; rd_used = 1'b1; rd_who = k;
                    end
                end
            end
            check("m_r0_ready", r0_req_ready, exp_g[0]);
            check("m_r1_ready", r1_req_ready, exp_g[1]);
            check("m_re", m_re, rd_used);
            check("m_we", m_we, wr_used);
            if (rd_used) begin
                check("m_rd_addr", m_rd_addr, req[rd_who].addr);
                check("m_rd_bytes", m_rd_bytes, req[rd_who].bytes);
                check("m_rd_unsigned", m_rd_unsigned, req[rd_who].is_unsigned);
            end
            if (wr_used) begin
                check("m_wr_addr", m_wr_addr, req[wr_who].addr);
                check("m_wr_bytes", m_wr_bytes, req[wr_who].bytes);
                check("m_wr_data", m_wr_data, req[wr_who].wdata);
            end

            for (int j = 0; j < 2; j++) begin
                if (exp_g[j]) begin
                    if (bad_req(req[j]))   e = {1'b1, 32'h0};
                    else if (req[j].write) e = {1'b0, 32'h0};
                    else e = {1'b0, load_val(ref_mem, req[j].addr, req[j].bytes, req[j].is_unsigned)};
                    if (j == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
                end
            end
            if (wr_used)
                for (int i = 0; i < (1 << req[wr_who].bytes); i++)
                    ref_mem[8'(req[wr_who].addr + W'(i))] = req[wr_who].wdata[8*i +: 8];

            md_blk = rd_used && wr_used && ((req[rd_who].addr >> 2) != (req[wr_who].addr >> 2));
            if (vld[1] && !exp_g[1]) md_starve = (md_starve < MAX_WAIT) ? md_starve + 1 : MAX_WAIT;
            else md_starve = 0;
            for (int j = 0; j < 2; j++) begin
                prev_vld[j] = vld[j];
                prev_g[j]   = exp_g[j];
                prev_req[j] = req[j];
            end
        end
    end

    // driver tasks
    task automatic set_req(input int n, input logic v, input logic w, input logic [W-1:0] a,
                           input logic [2:0] b, input logic u, input logic [W-1:0] d);
        vld[n]             = v;
        req[n].write       = w;
        req[n].addr        = a;
        req[n].bytes       = b;
        req[n].is_unsigned = u;
        req[n].wdata       = d;
    endtask

    task automatic idle(input int n);
        set_req(n, 1'b0, 1'b0, '0, 3'd0, 1'b0, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit r1_exp;
        idle(0);
        idle(1);
        // reset with a request pending: nothing may be granted
        set_req(0, 1, 0, 32'h10, SZ_W, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_literal_ready", r0_req_ready, 0);

        // single load
        next_cycle(); rst_n = 1'b1;
        @(negedge clk);
        check("t1_m_re", m_re, 1);
        check("t1_rd_addr", m_rd_addr, 32'h10);
        next_cycle(); idle(0);
        @(negedge clk);
        check("t1_rsp_valid", r0_rsp_valid, 1);
        check("t1_rdata", r0_rsp_rdata, 32'h4342_4140);

        // dual issue to different words, then blocked write
        next_cycle();
        set_req(0, 1, 1, 32'h20, SZ_W, 0, 32'hDEAD_BEEF);
        set_req(1, 1, 0, 32'h40, SZ_W, 0, 0);
        @(negedge clk);
        check("t2_ready0", r0_req_ready, 1);
        check("t2_ready1", r1_req_ready, 1);
        check("t2_dual", {m_we, m_re}, 2'b11);
        next_cycle();
        set_req(0, 1, 0, 32'h20, SZ_W, 0, 0);
        set_req(1, 1, 1, 32'h44, SZ_W, 0, 32'h1234_5678);
        @(negedge clk);
        check("t2_blk_r1_ready", r1_req_ready, 0);
        check("t2_blk_r0_ready", r0_req_ready, 1);
        check("t2_blk_m_we", m_we, 0);
        check("t2_r1_rdata", r1_rsp_rdata, 32'h7372_7170);
        next_cycle(); idle(0);
        @(negedge clk);
        check("t2_retry_ready", r1_req_ready, 1);
        check("t2_retry_addr", m_wr_addr, 32'h44);
        check("t2_r0_rdata", r0_rsp_rdata, 32'hDEAD_BEEF);
        next_cycle(); idle(1);

        // starvation: r1 wins after MAX_WAIT stalls, twice
        for (int k = 0; k < 11; k++) begin
            set_req(0, 1, 0, 32'h00, SZ_W, 0, 0);
            if (k < 10) set_req(1, 1, 0, (k < 5) ? 32'h04 : 32'h08, SZ_W, 0, 0);
            else idle(1);
            @(negedge clk);
            r1_exp = (k == 4 || k == 9);
            check("t3_r1_ready", r1_req_ready, r1_exp);
            check("t3_r0_ready", r0_req_ready, !r1_exp);
            next_cycle();
        end
        idle(0);

        // r1 misaligned half alongside r0 legal half
        set_req(1, 1, 0, 32'h13, SZ_H, 0, 0);
        set_req(0, 1, 0, 32'h12, SZ_H, 0, 0);
        @(negedge clk);
        check("t4_ready0", r0_req_ready, 1);
        check("t4_ready1", r1_req_ready, 1);
        check("t4_rd_addr", m_rd_addr, 32'h12);
        next_cycle(); idle(0); idle(1);
        @(negedge clk);
        check("t4_r1_err", r1_rsp_err, 1);
        check("t4_r1_rdata", r1_rsp_rdata, 0);
        check("t4_r0_rdata", r0_rsp_rdata, 32'h0000_4342);

        // illegal size from r0 does not block r1
        next_cycle();
        set_req(0, 1, 0, 32'h30, SZ_D, 0, 0);
        set_req(1, 1, 0, 32'h30, SZ_W, 0, 0);
        @(negedge clk);
        check("t4b_ready0", r0_req_ready, 1);
        check("t4b_rd_addr", m_rd_addr, 32'h30);
        next_cycle(); idle(0); idle(1);
        @(negedge clk);
        check("t4b_r0_err", r0_rsp_err, 1);
        check("t4b_r1_rdata", r1_rsp_rdata, 32'h6362_6160);

        // byte store then unsigned / signed byte loads
        next_cycle(); set_req(0, 1, 1, 32'h21, SZ_B, 0, 32'h5A);
        @(negedge clk);
        check("t5_wr_addr", m_wr_addr, 32'h21);
        next_cycle(); set_req(0, 1, 0, 32'h21, SZ_B, 1, 0);
        next_cycle(); set_req(0, 1, 1, 32'h22, SZ_B, 0, 32'h9C);
        @(negedge clk);
        check("t5_ubyte", r0_rsp_rdata, 32'h0000_005A);
        next_cycle(); set_req(0, 1, 0, 32'h22, SZ_B, 0, 0);
        next_cycle(); idle(0);
        @(negedge clk);
        check("t5_sbyte", r0_rsp_rdata, 32'hFFFF_FF9C);

        // dual issue within one word: no write block afterwards
        next_cycle();
        set_req(0, 1, 1, 32'h52, SZ_H, 0, 32'h1234);
        set_req(1, 1, 0, 32'h50, SZ_H, 0, 0);
        @(negedge clk);
        check("t6_dual", {m_we, m_re}, 2'b11);
        next_cycle(); idle(0);
        set_req(1, 1, 1, 32'h54, SZ_W, 0, 32'hCAFE_F00D);
        @(negedge clk);
        check("t6_no_block", r1_req_ready, 1);
        check("t6_r1_rdata", r1_rsp_rdata, 32'hFFFF_8180);
        next_cycle(); idle(1);

        // two writes contend: r0 first, r1 next cycle
        set_req(0, 1, 1, 32'h60, SZ_W, 0, 32'h0000_000A);
        set_req(1, 1, 1, 32'h64, SZ_W, 0, 32'h0000_000B);
        @(negedge clk);
        check("t7_r1_stall", r1_req_ready, 0);
        check("t7_wr_addr0", m_wr_addr, 32'h60);
        next_cycle(); idle(0);
        @(negedge clk);
        check("t7_r1_ready", r1_req_ready, 1);
        check("t7_wr_addr1", m_wr_addr, 32'h64);
        next_cycle(); idle(1);

        // reset between grant and response drops the response
        set_req(0, 1, 0, 32'h10, SZ_W, 0, 0);
        @(negedge clk);
        check("t8_grant", r0_req_ready, 1);
        next_cycle(); rst_n = 1'b0;
        @(negedge clk);
        check("t8_no_rsp", r0_rsp_valid, 0);
        check("t8_m_re", m_re, 0);
        next_cycle(); rst_n = 1'b1;
        set_req(0, 1, 0, 32'h14, SZ_W, 0, 0);
        @(negedge clk);
        check("t8_fresh_re", m_re, 1);
        next_cycle(); idle(0);
        @(negedge clk);
        check("t8_fresh_valid", r0_rsp_valid, 1);
        check("t8_fresh_rdata", r0_rsp_rdata, 32'h4746_4544);
        next_cycle();
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data load/store port of the memory manager between two requesters: requester 0 (core LSU) and requester 1 (debug/DMA master).
- Uses valid/ready per requester and a fixed one-cycle response slot.
- Dual-issues one read and one write in the same cycle when both are present and safe.
- Enforces the memory manager's rule that no write may follow a deferred write.
- Sits between the core/debug masters and the memory manager; the instruction port is untouched.

Parameters:
- WIDTH, 32, data/address width; must match the memory manager.
- MAX_WAIT, 4, consecutive stalled cycles of requester 1 before it takes priority.
- BYTES, WIDTH/8, derived; size codes above $clog2(BYTES) are illegal.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- rN_req_valid  in  1  request present (N = 0, 1; the rN_ signals below exist per requester).
- rN_req_ready  out  1  request accepted this cycle (combinational grant).
- rN_req_write  in  1  1 = store, 0 = load.
- rN_req_addr  in  WIDTH  byte address.
- rN_req_bytes  in  3  size code: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B, 4 = 16 B.
- rN_req_unsigned  in  1  zero-extend load.
- rN_req_wdata  in  WIDTH  store data, LSB-aligned.
- rN_rsp_valid  out  1  response pulse.
- rN_rsp_rdata  out  WIDTH  load data; 0 for stores and errors.
- rN_rsp_err  out  1  misaligned or illegal size; no memory access was made.
- m_wr_addr  out  WIDTH  write address to memory manager.
- m_we  out  1  write enable.
- m_wr_bytes  out  3  write size code.
- m_wr_data  out  WIDTH  write data.
- m_rd_addr  out  WIDTH  read address.
- m_re  out  1  read enable.
- m_rd_bytes  out  3  read size code.
- m_rd_unsigned  out  1  read zero-extend.
- m_rd_data  in  WIDTH  read data, valid the cycle after m_re.

Behaviour:
- Reset (rst_n low, async): rsp_valid, rsp_err, m_we, m_re and rN_req_ready are 0; wr_block = 0; starve_cnt = 0; pending response slots cleared.
- In-flight responses at reset are dropped, with no rsp_valid.
- First grant is possible in the first cycle after rst_n rises.
- Legality check (combinational, per request):
  - err if bytes > $clog2(BYTES) or addr[bytes-1:0] != 0.
  - An erroneous request is accepted immediately (ready = 1) without using a port.
  - It is answered next cycle with rsp_err = 1 and rdata = 0.
- Port classes: a legal read needs the RD port; a legal write needs the WR port. WR is unavailable while wr_block = 1.
- Grant rules, evaluated each cycle:
  - Only one valid and its port free: grant it.
  - Both valid, different ports, both free: grant both (dual issue).
  - Both need the same port, or one is blocked: the priority holder wins. Priority holder is requester 0 unless starve_cnt == MAX_WAIT, in which case it is requester 1.
  - Requester 0's erroneous requests never conflict with requester 1.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) when r1_req_valid = 1 and r1_req_ready = 0.
  - Clears on any r1 grant or when r1_req_valid = 0.
- wr_block:
  - Set for exactly the next cycle after any dual-issue cycle whose aligned read and write addresses differ (the memory manager defers that write).
  - Clears after one cycle.
  - A write requested during wr_block stalls (ready = 0); a read still proceeds.
- Issue: m_re/m_we and the m_* fields are driven combinationally from the granted request. Unused fields are don't-care, but m_we/m_re are strictly 0.
- Response:
  - Exactly one cycle after grant, rN_rsp_valid = 1.
  - Loads return rdata = m_rd_data; stores return rdata = 0 and err = 0.
  - No backpressure; each requester has at most one response per cycle.
  - Back-to-back grants give back-to-back responses.
- Payload must stay stable while valid && !ready (bench assertion).
- Simultaneous load and store by the same requester is impossible (one request per requester per cycle).

Decomposition:
- Package mem_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_D, SZ_Q).
  - mem_req_t struct (write, addr, bytes, unsigned, wdata).
  - function is_misaligned(addr, bytes, width).
- Sub-module arb_rsp_tracker: per-requester one-deep response register (valid, is_read, err), with rdata steering from m_rd_data.
- Arbiter core (grant logic, starve_cnt, wr_block) stays in mem_port_arbiter.

Test Plan:
- r0 load W @0x10 alone → m_re = 1, m_rd_addr = 0x10 in cycle 0; r0_rsp_valid = 1 in cycle 1 with rdata = memory word at 0x10.
- r0 store W 0xDEADBEEF @0x20 and r1 load W @0x40 same cycle → both ready, m_we = m_re = 1. Next cycle: r1 store @0x44 stalls (wr_block); a concurrent r0 load proceeds. The r1 store is issued the cycle after.
- r0 and r1 both load continuously → r0 wins 4 cycles, then r1 granted on cycle 5 (MAX_WAIT = 4); starve_cnt returns to 0.
- r1 load H @0x13 → ready same cycle, no m_re, r1_rsp_err = 1 and rdata = 0 next cycle. r0 load H @0x12 issues that same cycle unaffected.
- Store B 0x5A @0x21, then load B unsigned @0x21 next cycle → rdata = 0x0000005A. Load B signed of 0x9C → 0xFFFFFF9C.
- Assert rst_n low in the cycle between a load grant and its response → no rsp_valid, m_re = 0 immediately. After release, a fresh load completes normally.
